ps2_keyboard: RTL and testbench
===============================

Name: ps2_keyboard

Overview:
PS/2 device-to-host receiver that deserialises 11-bit keyboard frames into scan-code bytes and queues them in a small FIFO for the consumer. It is instantiated in the top level next to the VGA controller and LED block, clocked by the system clock. Only valid frames (correct start, odd parity, stop) are queued. The consumer pops bytes with an active-low strobe.

Parameters:
FIFO_DEPTH, 8, number of byte entries in the receive FIFO; must be a power of two, at least 2.
SYNC_STAGES, 2, number of flops in the synchroniser for ps2_clk and ps2_data; at least 2.

Ports:
clk  input  1  system clock; all logic rises on posedge.
resetn  input  1  asynchronous, active-low reset.
ps2_clk  input  1  raw PS/2 clock from the device (asynchronous).
ps2_data  input  1  raw PS/2 data from the device (asynchronous).
nextdata_n  input  1  active-low pop request; one byte consumed per clk cycle it is low while ready=1.
data  output  8  byte at the FIFO head; valid only while ready=1.
ready  output  1  FIFO non-empty.
overflow  output  1  sticky flag: a valid frame was dropped because the FIFO was full.

Behaviour:
- Reset (resetn=0, asynchronous) clears the synchronisers, edge detector, bit counter, shift register, FIFO pointers and overflow. Outputs during and after reset: ready=0, overflow=0, data=8'h00.
- Synchronisation: ps2_clk and ps2_data each pass through SYNC_STAGES flops. One extra flop on ps2_clk gives a falling-edge pulse (previous=1, current=0).
- Sampling: on each falling-edge pulse, the synchronised ps2_data is stored at bit index cnt of a 10-bit shift buffer, and cnt increments (0..9).
- Frame end: on the falling-edge pulse while cnt==10:
  - the current sample is the stop bit;
  - the frame is valid if buffer[0]==0 (start), the stop bit is 1, and XOR of buffer[9:1] is 1 (odd parity over 8 data bits plus parity bit);
  - a valid frame pushes buffer[8:1] (LSB first on the wire) into the FIFO;
  - a valid frame or an invalid one resets cnt to 0, and an invalid frame is silently discarded.
- Latency: ready rises no later than SYNC_STAGES+2 clk cycles after the 11th ps2_clk falling edge at the pin.
- FIFO: write pointer and read pointer, each log2(FIFO_DEPTH)+1 bits wide; wrap-around is modulo 2*FIFO_DEPTH.
  - empty when the pointers are equal; full when the low bits are equal and the MSBs differ.
  - ready = !empty. data = mem[rd_ptr] (combinational read).
- Pop: while nextdata_n==0 and ready==1, rd_ptr advances by one on each clk edge. nextdata_n==0 while empty has no effect.
- Push when full, with no pop in the same cycle: the byte is dropped and overflow is set. overflow stays 1 until reset; further pops and pushes do not clear it.
- Simultaneous push and pop: both take effect, including when full, where the push is accepted and overflow is not set. Occupancy is unchanged.
- Frame timing: no timeout. A partial frame persists until more edges arrive or reset occurs. Reset mid-frame discards the partial frame.
- Device timing: ps2_clk high and low phases must each be at least SYNC_STAGES+2 clk cycles. ps2_data changes only while ps2_clk is high.

Decomposition:
- Shared package ps2_pkg holds:
  - constants FRAME_BITS=11 and SCAN_W=8;
  - a function for odd-parity check.
- One natural sub-module: ps2_rx_fifo (parameterised synchronous FIFO with push, pop, full, empty and a combinational head read).
- Synchroniser, edge detect and deserialiser stay in ps2_keyboard.

Test Plan:
- Reset release with idle lines (ps2_clk=1, ps2_data=1) -> ready=0, overflow=0, data=8'h00 for 100 cycles.
- Frame for 0x1C: bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1, with 10-cycle phases.
  - Expect ready=1 and data=8'h1C within 4 cycles of the 11th fall.
  - Pulse nextdata_n low for 1 cycle -> ready=0.
- Same frame with parity bit 1 -> ready stays 0 and overflow stays 0. A following good frame 0xF0 is then received correctly, so the bit counter resynchronised.
- Send 9 valid frames (bytes 0x01..0x09) with no pops.
  - Expect overflow=1 after the 9th frame.
  - Popping yields 0x01..0x08 in order, then ready=0.
- Hold nextdata_n low while a frame completes into an empty FIFO -> the byte is popped on the cycle after it appears; ready pulses for exactly 1 cycle.
- Assert resetn=0 after the 5th falling edge of a frame, then release and send a full 0x2A frame -> data=8'h2A; the partial frame leaves no trace.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and helpers for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam int FRAME_BITS = 11;
    localparam int SCAN_W     = 8;

    // Data bits plus parity bit must contain an odd number of ones.
    function automatic logic odd_parity(input logic [SCAN_W:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ps2_keyboard_if.sv
// PS/2 line pins plus the consumer-side byte port of the keyboard receiver.
interface ps2_keyboard_if;
    import ps2_pkg::*;

    logic              ps2_clk;
    logic              ps2_data;
    logic              nextdata_n;
    logic [SCAN_W-1:0] data;
    logic              ready;
    logic              overflow;

    // Consumer handshake: a byte is taken on every clk edge where ready=1 and nextdata_n=0.
    modport slave  (input  ps2_clk, ps2_data, nextdata_n,
                    output data, ready, overflow);
    modport master (output ps2_clk, ps2_data, nextdata_n,
                    input  data, ready, overflow);
endinterface

// File: rtl/ps2_rx_fifo.sv
// Synchronous FIFO with extra-MSB pointers and a combinational head read.
module ps2_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end
endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver: synchronise, deserialise 11-bit frames, queue valid scan codes.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    ps2_keyboard_if.slave bus
);
    localparam int CNT_W = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    logic [SYNC_STAGES-1:0]  clk_sync_q, data_sync_q;
    logic                    clk_prev_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FRAME_BITS-2:0]   buf_q, buf_d;
    logic                    overflow_q, overflow_d;

    logic clk_cur, data_cur, fall, frame_end, frame_ok, push;
    logic fifo_full, fifo_empty;

    assign clk_cur   = clk_sync_q[SYNC_STAGES-1];
    assign data_cur  = data_sync_q[SYNC_STAGES-1];
    assign fall      = clk_prev_q && !clk_cur;
    assign frame_end = fall && (cnt_q == LAST_IDX);
    // Start low, stop (current sample) high, odd parity over data+parity.
    assign frame_ok  = !buf_q[0] && data_cur && odd_parity(buf_q[FRAME_BITS-2:1]);
    assign push      = frame_end && frame_ok;

    always_comb begin
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        overflow_d = overflow_q;
        if (frame_end) begin
            cnt_d = '0;
        end else if (fall) begin
            buf_d[cnt_q] = data_cur;
            cnt_d        = cnt_q + CNT_ONE;
        end
        // A pop in the same cycle lets a full FIFO take the byte.
        if (push && fifo_full && bus.nextdata_n) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            clk_prev_q  <= 1'b0;
            cnt_q       <= '0;
            buf_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.ps2_data};
            clk_prev_q  <= clk_cur;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            overflow_q  <= overflow_d;
        end
    end

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (SCAN_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (resetn),
        .push_i  (push),
        .din_i   (buf_q[SCAN_W:1]),
        .pop_i   (!bus.nextdata_n),
        .dout_o  (bus.data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.ready    = !fifo_empty;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: frame reception, parity reject, overflow, pop-through and mid-frame reset.
module tb_ps2_keyboard;
    localparam int HALF = 10;

    logic clk;
    logic resetn;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] exp_q[$];

    ps2_keyboard_if bus();

    ps2_keyboard #(
        .FIFO_DEPTH  (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive the first nfalls bits of a frame; returns right after the last falling edge with ps2_clk low.
    task automatic send_falls(input logic [7:0] b, input bit bad_par, input int nfalls);
        logic [10:0] f;
        logic        par;
        par = ~(^b) ^ bad_par;
        f   = {1'b1, par, b, 1'b0};
        for (int i = 0; i < nfalls; i++) begin
            bus.ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b0;
            if (i < nfalls - 1) begin
                repeat (HALF) @(negedge clk);
                bus.ps2_clk = 1'b1;
            end
        end
    endtask

    task automatic release_lines();
        repeat (HALF) @(negedge clk);
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        send_falls(b, bad_par, 11);
        repeat (4) @(negedge clk);
        release_lines();
    endtask

    task automatic pop_one();
        bus.nextdata_n = 1'b0;
        @(negedge clk);
        bus.nextdata_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int         seen;
        logic [7:0] seen_data;

        bus.ps2_clk    = 1'b1;
        bus.ps2_data   = 1'b1;
        bus.nextdata_n = 1'b1;
        resetn         = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 0);
        chk("rst_data", 32'(bus.data), 32'h00);
        resetn = 1'b1;

        // Idle lines after reset
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_ready", 32'(bus.ready), 0);
            chk("idle_ovf", 32'(bus.overflow), 0);
            chk("idle_data", 32'(bus.data), 32'h00);
        end

        // Single 0x1C frame with latency bound
        send_falls(8'h1C, 1'b0, 11);
        repeat (4) @(negedge clk);
        chk("1c_ready", 32'(bus.ready), 1);
        chk("1c_data", 32'(bus.data), 32'h1C);
        release_lines();
        pop_one();
        chk("1c_pop_ready", 32'(bus.ready), 0);

        // Bad parity is discarded, next frame still decodes
        send_frame(8'h1C, 1'b1);
        chk("badpar_ready", 32'(bus.ready), 0);
        chk("badpar_ovf", 32'(bus.overflow), 0);
        send_frame(8'hF0, 1'b0);
        chk("f0_ready", 32'(bus.ready), 1);
        chk("f0_data", 32'(bus.data), 32'hF0);
        pop_one();
        chk("f0_pop_ready", 32'(bus.ready), 0);

        // Nine frames into an 8-deep FIFO
        for (int k = 1; k <= 9; k++) begin
            send_frame(8'(k), 1'b0);
            if (k <= 8) exp_q.push_back(8'(k));
            if (k == 8) chk("ovf_before", 32'(bus.overflow), 0);
        end
        chk("ovf_after", 32'(bus.overflow), 1);
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("drain_ready", 32'(bus.ready), 1);
            chk("drain_data", 32'(bus.data), 32'(e));
            pop_one();
        end
        chk("drain_empty", 32'(bus.ready), 0);
        chk("ovf_sticky", 32'(bus.overflow), 1);

        // Pop held low while a byte lands in an empty FIFO
        bus.nextdata_n = 1'b0;
        send_falls(8'h5A, 1'b0, 11);
        seen      = 0;
        seen_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                seen++;
                seen_data = bus.data;
            end
        end
        chk("hold_pulse_len", 32'(seen), 1);
        chk("hold_data", 32'(seen_data), 32'h5A);
        chk("hold_ready_end", 32'(bus.ready), 0);
        bus.nextdata_n = 1'b1;
        release_lines();

        // Reset mid-frame, then a clean 0x2A frame
        send_falls(8'hFF, 1'b0, 5);
        repeat (3) @(negedge clk);
        resetn       = 1'b0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        repeat (HALF) @(negedge clk);
        chk("midrst_ready", 32'(bus.ready), 0);
        chk("midrst_ovf", 32'(bus.overflow), 0);
        send_frame(8'h2A, 1'b0);
        chk("2a_ready", 32'(bus.ready), 1);
        chk("2a_data", 32'(bus.data), 32'h2A);
        pop_one();
        chk("2a_pop_ready", 32'(bus.ready), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
